cc_sequencer: RTL and testbench
===============================

# cc_sequencer

Controller that runs one cross-correlation pass on the `cc_1` core. On a host request it pulses the core's reset and start, streams `NSAMP` sample pairs out of dual sample memories (synchronous read, 1-cycle latency) into the core, and waits for `done` with a watchdog. It then captures the signed lag index and holds it for the host under a valid/ack handshake. It sits between the host/control logic and the correlation datapath, replacing the bench-driven sequencing.

## Interface
- `NSAMP`, 12800: sample pairs streamed per pass (≥2).
- `ADDR_W`, 18: sample memory address width.
- `LAG_W`, 10: width of the signed lag index.
- `TIMEOUT`, 65535: maximum cycles in WAIT before an error.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: host start request; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `mem_addr` out ADDR_W: read address to both sample memories.
- `mem_en` out 1: read enable.
- `mem_rd0`, `mem_rd1` in 16: read data, valid the cycle after `mem_en`.
- `cc_rst` out 1: active-high reset to the core.
- `cc_start` out 1: start pulse to the core.
- `cc_m0`, `cc_m1` out 16: sample inputs to the core.
- `cc_done` in 1: core completion.
- `cc_index` in LAG_W: core lag result, two's complement.
- `res_valid` out 1: result available.
- `res_lag` out LAG_W: captured lag, signed.
- `res_err` out 1: pass ended by timeout; `res_lag` = 0.
- `res_ack` in 1: host consumes the result.

## Operation
- States: IDLE → CLR → ARM → STREAM → WAIT → DONE → IDLE.
- IDLE: `req`=1 → CLR.
- CLR: one cycle with `cc_rst`=1 → ARM.
- ARM: one cycle with `cc_start`=1, `mem_en`=1, `mem_addr`=0. Sample counter `k` cleared → STREAM.
- STREAM: `mem_en`=1, `mem_addr`=k+1. Core receives sample k on `cc_m0`/`cc_m1`, wired combinationally from `mem_rd0`/`mem_rd1`. At k=NSAMP−1: `mem_en`=0 (no read past the end) → WAIT. `cc_done` is ignored in STREAM.
- WAIT: watchdog counts up from 0.
  - `cc_done`=1 → capture `cc_index` into `res_lag`, `res_err`=0 → DONE.
  - Watchdog reaches TIMEOUT−1 without `cc_done` → `res_lag`=0, `res_err`=1 → DONE.
  - If `cc_done` and the timeout occur in the same cycle, `cc_done` wins.
- DONE: `res_valid`=1 with `res_lag`/`res_err` stable. `res_ack`=1 → IDLE, `res_valid` drops the next cycle. A `req` in the ack cycle is not taken; the host re-asserts it.
- `req` outside IDLE is ignored and not queued.
- `cc_m0`/`cc_m1` outside STREAM: driven 0.
- Widths:
  - `k` is ADDR_W bits.
  - The watchdog is clog2(TIMEOUT+1) bits and saturates; it never wraps.
  - `res_lag` is a straight copy of `cc_index`, with no sign extension.

## Timing
- Reset (async assert, sync deassert by the integrator): state IDLE. All outputs 0: `busy`, `mem_en`, `mem_addr`, `cc_rst`, `cc_start`, `cc_m0`, `cc_m1`, `res_valid`, `res_lag`, `res_err`.
- Reset mid-pass aborts immediately. After release the core still holds stale state, but the next pass's CLR cycle clears it.
- `req` high at edge t → `cc_rst` high during t+1 → `cc_start` high during t+2 → sample k presented during t+3+k.
- Last sample at t+2+NSAMP; WAIT is entered at t+3+NSAMP.
- `cc_done` high at edge w → `res_valid` high from w+1.
- `busy` rises the cycle after `req` is accepted and falls with the transition to IDLE.
- All outputs are registered except `cc_m0`/`cc_m1`, which pass through a single gating level.

## Structure
- Shared package `cc_pkg`:
  - state enum (IDLE, CLR, ARM, STREAM, WAIT, DONE);
  - defaults for NSAMP, LAG_W and sample width 16.
- One sub-module, `cc_watchdog`: clear/enable/saturating counter with a `expired` flag.
- Sample counter and FSM live in the top.

## Test plan
- **Nominal pass.** NSAMP=16; behavioural core asserts `cc_done` 5 cycles after the last sample with `cc_index`=−31. Require:
  - `mem_addr` sequence 0..15, with sample k seen at t+3+k;
  - `res_lag`=−31 (0x3E1), `res_err`=0.
- **Timeout.** TIMEOUT=20, core never asserts `cc_done` → `res_valid` exactly 20 cycles after WAIT entry, `res_err`=1, `res_lag`=0.
- **Ignored events.**
  - `req` pulses during STREAM and WAIT → no restart and no second CLR.
  - `cc_done` asserted at k=3 of STREAM → ignored; the result is taken from the later `cc_done`.
- **Back-to-back passes.**
  - `res_ack` and `req` high together in DONE → IDLE, no new pass.
  - `req` the next cycle → a second pass with `cc_index`=+7 yields `res_lag`=7.
- **Reset mid-pass.** `rst_n` low at k=8 → all outputs 0 asynchronously. After release, a new `req` gives a full CLR/ARM/16-sample sequence from `mem_addr`=0.
- **Timeout tie-break.** `cc_done` in the same cycle the watchdog expires → `res_err`=0 and the index is captured.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and default sizes for the cross-correlation pass sequencer.
package cc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_ARM    = 3'd2,
      ST_STREAM = 3'd3,
      ST_WAIT   = 3'd4,
      ST_DONE   = 3'd5
   } cc_state_e;

   localparam int CC_NSAMP_DEF   = 12800;
   localparam int CC_ADDR_W_DEF  = 18;
   localparam int CC_LAG_W_DEF   = 10;
   localparam int CC_TIMEOUT_DEF = 65535;
   localparam int CC_SAMP_W      = 16;

endpackage

// File: rtl/cc_watchdog.sv
// Saturating up-counter used to bound the wait for the core's completion.
// expired_o rises once the count reaches LIMIT-1 and stays high while held.
module cc_watchdog #(
   parameter int LIMIT = 65535,
   parameter int CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;

   // Count while enabled; stop at all-ones so the counter can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign expired_o = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/cc_sequencer.sv
// Runs one cross-correlation pass on the cc_1 core: clear, start, stream
// NSAMP sample pairs from the dual sample memories, wait for done under a
// watchdog, then hold the signed lag for the host until acknowledged.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for req; all outputs quiet
//   CLR    | one cycle of cc_rst to the core
//   ARM    | one cycle of cc_start; first memory read (address 0)
//   STREAM | sample k on cc_m0/cc_m1, read address k+1 in flight
//   WAIT   | waiting for cc_done, watchdog running
//   DONE   | result held with res_valid until res_ack
module cc_sequencer
   import cc_pkg::*;
#(
   parameter int NSAMP   = CC_NSAMP_DEF,
   parameter int ADDR_W  = CC_ADDR_W_DEF,
   parameter int LAG_W   = CC_LAG_W_DEF,
   parameter int TIMEOUT = CC_TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   output logic                 busy,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_en,
   input  logic [CC_SAMP_W-1:0] mem_rd0,
   input  logic [CC_SAMP_W-1:0] mem_rd1,
   output logic                 cc_rst,
   output logic                 cc_start,
   output logic [CC_SAMP_W-1:0] cc_m0,
   output logic [CC_SAMP_W-1:0] cc_m1,
   input  logic                 cc_done,
   input  logic [LAG_W-1:0]     cc_index,
   output logic                 res_valid,
   output logic [LAG_W-1:0]     res_lag,
   output logic                 res_err,
   input  logic                 res_ack
);

   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NSAMP - 1);
   localparam logic [ADDR_W-1:0] K_PEN  = ADDR_W'(NSAMP - 2);
   localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] K_TWO  = ADDR_W'(2);

   cc_state_e         state_q;
   logic [ADDR_W-1:0] k_q;
   logic [ADDR_W-1:0] k_d;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_en_q;
   logic              busy_q;
   logic              cc_rst_q;
   logic              cc_start_q;
   logic              res_valid_q;
   logic [LAG_W-1:0]  res_lag_q;
   logic              res_err_q;
   logic              wd_expired;

   // Next sample index and the read address that keeps one read ahead of it.
   assign k_d    = k_q + K_ONE;
   assign addr_d = k_q + K_TWO;

   cc_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q != ST_WAIT),
      .en_i      (state_q == ST_WAIT),
      .expired_o (wd_expired)
   );

   // Pass sequencing with every control output registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         mem_addr_q  <= '0;
         mem_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         cc_rst_q    <= 1'b0;
         cc_start_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_lag_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         cc_rst_q   <= 1'b0;
         cc_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  state_q   <= ST_CLR;
                  busy_q    <= 1'b1;
                  cc_rst_q  <= 1'b1;
                  res_lag_q <= '0;
                  res_err_q <= 1'b0;
               end
            end
            ST_CLR: begin
               state_q    <= ST_ARM;
               cc_start_q <= 1'b1;
               mem_en_q   <= 1'b1;
               mem_addr_q <= '0;
               k_q        <= '0;
            end
            ST_ARM: begin
               // NSAMP >= 2, so address 1 is always a valid read here.
               state_q    <= ST_STREAM;
               mem_en_q   <= 1'b1;
               mem_addr_q <= K_ONE;
               k_q        <= '0;
            end
            ST_STREAM: begin
               // cc_done is deliberately not looked at until all samples are out.
               if (k_q == K_LAST) begin
                  state_q    <= ST_WAIT;
                  mem_en_q   <= 1'b0;
                  mem_addr_q <= '0;
               end else begin
                  k_q        <= k_d;
                  mem_addr_q <= addr_d;
                  // The read issued in the last sample cycle would be past the end.
                  mem_en_q   <= (k_q != K_PEN);
               end
            end
            ST_WAIT: begin
               if (cc_done) begin
                  state_q     <= ST_DONE;
                  res_valid_q <= 1'b1;
                  res_lag_q   <= cc_index;
                  res_err_q   <= 1'b0;
               end else if (wd_expired) begin
                  state_q     <= ST_DONE;
                  res_valid_q <= 1'b1;
                  res_lag_q   <= '0;
                  res_err_q   <= 1'b1;
               end
            end
            ST_DONE: begin
               // A req arriving with the ack is dropped; the host must re-assert.
               if (res_ack) begin
                  state_q     <= ST_IDLE;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               mem_en_q    <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign mem_addr  = mem_addr_q;
   assign mem_en    = mem_en_q;
   assign cc_rst    = cc_rst_q;
   assign cc_start  = cc_start_q;
   assign res_valid = res_valid_q;
   assign res_lag   = res_lag_q;
   assign res_err   = res_err_q;

   // Memory read data reaches the core only while streaming.
   assign cc_m0 = (state_q == ST_STREAM) ? mem_rd0 : '0;
   assign cc_m1 = (state_q == ST_STREAM) ? mem_rd1 : '0;

endmodule

// File: tb/tb_cc_sequencer.sv
// Bench for cc_sequencer with a small sample memory and behavioural core.
module tb_cc_sequencer;

   localparam int NS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        busy;
   logic [17:0] mem_addr;
   logic        mem_en;
   logic [15:0] mem_rd0 = 16'h1234;
   logic [15:0] mem_rd1 = 16'h4321;
   logic        cc_rst;
   logic        cc_start;
   logic [15:0] cc_m0;
   logic [15:0] cc_m1;
   logic        cc_done = 1'b0;
   logic [9:0]  core_idx = '0;
   logic        res_valid;
   logic [9:0]  res_lag;
   logic        res_err;
   logic        res_ack = 1'b0;

   int core_delay = -1;
   bit core_early = 1'b0;

   typedef struct {
      logic [9:0] lag;
      logic       err;
      int         off;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] samp_q[$];
   bit          clr_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   cc_sequencer #(
      .NSAMP   (NS),
      .ADDR_W  (18),
      .LAG_W   (10),
      .TIMEOUT (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_en    (mem_en),
      .mem_rd0   (mem_rd0),
      .mem_rd1   (mem_rd1),
      .cc_rst    (cc_rst),
      .cc_start  (cc_start),
      .cc_m0     (cc_m0),
      .cc_m1     (cc_m1),
      .cc_done   (cc_done),
      .cc_index  (core_idx),
      .res_valid (res_valid),
      .res_lag   (res_lag),
      .res_err   (res_err),
      .res_ack   (res_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] samp_word(input int k);
      logic [15:0] a;
      logic [15:0] b;
      a = 16'hA000 + 16'(k);
      b = 16'h5A00 ^ 16'(k * 7);
      return {a, b};
   endfunction

   // Dual sample memory, one-cycle read latency; data holds when not read.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rd0 <= 16'hA000 + 16'(mem_addr);
         mem_rd1 <= 16'h5A00 ^ 16'(mem_addr * 7);
      end
   end

   // Behavioural core: done pulse a programmed number of cycles after the last sample.
   int core_start = 0;
   bit core_act = 1'b0;
   always @(negedge clk) begin
      int rel;
      if (!rst_n || cc_rst) begin
         core_act = 1'b0;
         cc_done  = 1'b0;
      end else begin
         if (cc_start) begin
            core_act   = 1'b1;
            core_start = cyc;
         end
         rel = cyc - core_start;
         cc_done = core_act && ((core_early && rel == 4) ||
                                (core_delay >= 0 && rel == NS + core_delay));
      end
   end

   // Monitor: pops expectations as the DUT presents clears, samples and results.
   int  stream_left = 0;
   bit  post_chk = 1'b0;
   int  start_cyc = 0;
   int  last_rst_cyc = -10;
   int  exp_addr = 0;
   bit  prev_valid = 1'b0;
   always @(negedge clk) begin
      logic [31:0] s;
      exp_t e;
      if (!rst_n) begin
         stream_left = 0;
         post_chk    = 1'b0;
         prev_valid  = 1'b0;
      end else begin
         if (cc_rst) begin
            check("clr_expected", 32'(clr_q.size() != 0), 32'd1);
            if (clr_q.size() != 0) void'(clr_q.pop_front());
            last_rst_cyc = cyc;
         end
         if (cc_start) begin
            check("start_one_after_clr", 32'(cyc - last_rst_cyc), 32'd1);
            start_cyc   = cyc;
            exp_addr    = 0;
            stream_left = NS;
         end else if (stream_left > 0) begin
            if (samp_q.size() == 0) begin
               check("sample_expected", 32'd0, 32'd1);
            end else begin
               s = samp_q.pop_front();
               check("sample_pair", {cc_m0, cc_m1}, s);
            end
            stream_left--;
            if (stream_left == 0) post_chk = 1'b1;
         end else if (post_chk) begin
            check("samples_gated_after_stream", {cc_m0, cc_m1}, 32'd0);
            post_chk = 1'b0;
         end
         if (mem_en) begin
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            exp_addr++;
         end
         if (res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("result_expected", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("res_lag", 32'(res_lag), 32'(e.lag));
               check("res_err", 32'(res_err), 32'(e.err));
               check("valid_latency", 32'(cyc - start_cyc), 32'(e.off));
               check("read_count", 32'(exp_addr), 32'(NS));
            end
         end
         prev_valid = res_valid;
      end
   end

   task automatic run_pass(input logic [9:0] idx, input int delay, input bit early,
                           input bit extra_req, input bit ack_with_req,
                           input logic [9:0] exp_lag, input bit exp_err, input int exp_off);
      exp_t e;
      int n;
      core_idx   = idx;
      core_delay = delay;
      core_early = early;
      e.lag = exp_lag;
      e.err = exp_err;
      e.off = exp_off;
      exp_q.push_back(e);
      clr_q.push_back(1'b1);
      for (int k = 0; k < NS; k++) samp_q.push_back(samp_word(k));
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      if (extra_req) begin
         repeat (5) @(negedge clk);
         req = 1'b1;
         @(negedge clk);
         req = 1'b0;
         repeat (12) @(negedge clk);
         req = 1'b1;
         @(negedge clk);
         req = 1'b0;
      end
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("valid_arrives", 32'(res_valid), 32'd1);
      check("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      check("valid_held", 32'(res_valid), 32'd1);
      res_ack = 1'b1;
      req     = ack_with_req;
      @(negedge clk);
      res_ack = 1'b0;
      req     = 1'b0;
      check("valid_drop_after_ack", 32'(res_valid), 32'd0);
      check("busy_drop_after_ack", 32'(busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ctrl_outs", {26'd0, busy, mem_en, cc_rst, cc_start, res_valid, res_err}, 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_samples", {cc_m0, cc_m1}, 32'd0);
      check("rst_res_lag", 32'(res_lag), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal: done 5 cycles after the last sample, lag -31.
      run_pass(10'h3E1, 5, 1'b0, 1'b0, 1'b0, 10'h3E1, 1'b0, 22);
      repeat (2) @(negedge clk);

      // Timeout: no done, result 20 cycles after entering WAIT.
      run_pass(10'h0AB, -1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 37);
      repeat (2) @(negedge clk);

      // Early done and stray req pulses ignored; ack arrives together with req.
      run_pass(10'h064, 5, 1'b1, 1'b1, 1'b1, 10'h064, 1'b0, 22);
      // Re-asserted the very next cycle: second pass with +7.
      run_pass(10'h007, 5, 1'b0, 1'b0, 1'b0, 10'h007, 1'b0, 22);
      repeat (2) @(negedge clk);

      // Reset in the middle of streaming (k = 8).
      core_idx   = 10'h155;
      core_delay = 5;
      core_early = 1'b0;
      clr_q.push_back(1'b1);
      for (int k = 0; k < NS; k++) samp_q.push_back(samp_word(k));
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (10) @(negedge clk);
      check("midpass_busy", 32'(busy), 32'd1);
      check("midpass_k8_sample", 32'(cc_m0), 32'h0000A008);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ctrl", {26'd0, busy, mem_en, cc_rst, cc_start, res_valid, res_err}, 32'd0);
      check("async_rst_addr", 32'(mem_addr), 32'd0);
      check("async_rst_samples", {cc_m0, cc_m1}, 32'd0);
      @(negedge clk);
      samp_q.delete();
      exp_q.delete();
      clr_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_pass(10'h3FE, 5, 1'b0, 1'b0, 1'b0, 10'h3FE, 1'b0, 22);
      repeat (2) @(negedge clk);

      // Done in the same cycle the watchdog expires: done wins.
      run_pass(10'h200, 20, 1'b0, 1'b0, 1'b0, 10'h200, 1'b0, 37);
      repeat (3) @(negedge clk);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("samp_q_drained", 32'(samp_q.size()), 32'd0);
      check("clr_q_drained", 32'(clr_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
